// File: rtl/xray_pix_pkg.sv
// Shared definitions for the X-ray pixel stream source.
//   PIX_W            greyscale pixel width
//   IMG_WIDTH_DEF    default pixels per line
//   IMG_HEIGHT_DEF   default lines per frame
//   FRAME_PIX_DEF    default pixels per frame
//   stream_state_t   streamer FSM states
//   pix_beat_t       one stream beat: pixel plus its frame markers
package xray_pix_pkg;

  localparam int PIX_W          = 8;
  localparam int IMG_WIDTH_DEF  = 382;
  localparam int IMG_HEIGHT_DEF = 256;
  localparam int FRAME_PIX_DEF  = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } stream_state_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
    logic             eof;
  } pix_beat_t;

endpackage

// File: rtl/pix_skid_buf.sv
// Two-entry fall-through buffer of stream beats.
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous clear of all stored beats (incoming push is dropped)
//   push         push_beat is written this cycle (RAM data returning)
//   push_beat    beat to store
//   out_valid    a beat is presented on out_beat
//   out_ready    consumer accepts out_beat this cycle
//   out_beat     head beat; the pushed beat passes straight through when empty
//   occupancy    number of stored beats (0..2), excluding a pass-through beat
// Handshake: a beat transfers on a cycle where out_valid and out_ready are
// both high; while out_valid is high and out_ready low the head beat is held
// unchanged. The producer must never push when two beats are stored and no
// pop occurs; the streamer's read-issue rule guarantees this.
module pix_skid_buf
  import xray_pix_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  pix_beat_t  push_beat,
  output logic       out_valid,
  input  logic       out_ready,
  output pix_beat_t  out_beat,
  output logic [1:0] occupancy
);

  pix_beat_t  entry0;
  pix_beat_t  entry1;
  logic [1:0] count;
  logic       pop;

  always_comb begin
    out_valid = (count != 2'd0) || push;
    if (count != 2'd0) begin
      out_beat = entry0;
    end else if (push) begin
      out_beat = push_beat;
    end else begin
      out_beat = '0;
    end
  end

  assign pop       = out_valid & out_ready;
  assign occupancy = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            entry0 <= push_beat;
            count  <= 2'd1;
          end else if (count == 2'd1) begin
            entry1 <= push_beat;
            count  <= 2'd2;
          end
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Empty + push + pop is a pass-through: nothing is stored.
          if (count == 2'd1) begin
            entry0 <= push_beat;
          end else if (count == 2'd2) begin
            entry0 <= entry1;
            entry1 <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/xray_frame_streamer.sv
// Streams one frame of greyscale pixels from a synchronous image RAM
// (1-cycle read latency) in raster order with SOF/EOL/EOF markers.
//   clk, rst_n     clock, asynchronous active-low reset
//   start          1-cycle frame request, honoured only in IDLE
//   abort          synchronous abort back to IDLE, flushes buffered pixels
//   mem_rd_en      RAM read strobe
//   mem_addr       RAM read address (raster index)
//   mem_rdata      RAM data, valid the cycle after mem_rd_en
//   pix_data       stream pixel
//   pix_valid      stream valid
//   pix_ready      stream ready from the consumer
//   pix_sof/eol/eof frame, line and frame-end markers qualifying pix_data
//   busy           high from accepted start until the final beat completes
//   frame_sum      (XRAY_STREAM_CHECKSUM_EN) mod-2^16 sum of beat pixels
//   sum_valid      (XRAY_STREAM_CHECKSUM_EN) frame_sum is final
//   done           1-cycle pulse after the final beat
// Optional feature macro: XRAY_STREAM_CHECKSUM_EN.
// Handshake: a beat transfers when pix_valid and pix_ready are both high;
// while pix_valid is high and pix_ready low, pix_data and markers hold.
module xray_frame_streamer
  import xray_pix_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
`ifdef XRAY_STREAM_CHECKSUM_EN
  output logic [15:0]       frame_sum,
  output logic              sum_valid,
`endif
  output logic              done
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);

  stream_state_t     state;
  logic [ADDR_W-1:0] addr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              rd_pending;
  logic              pend_sof;
  logic              pend_eol;
  logic              pend_eof;
  logic [1:0]        occ;
  logic              pop;
  logic [2:0]        commit_cnt;
  logic              rd_en;
  logic              cur_sof;
  logic              cur_eol;
  logic              cur_eof;
  pix_beat_t         push_beat;
  pix_beat_t         out_beat;

  // Markers are decided when the read is issued and ride with the read
  // until the data comes back, so they always match their pixel.
  assign cur_sof = (col == '0) && (row == '0);
  assign cur_eol = (col == COL_W'(IMG_WIDTH - 1));
  assign cur_eof = cur_eol && (row == ROW_W'(IMG_HEIGHT - 1));

  assign push_beat = '{data: mem_rdata, sof: pend_sof, eol: pend_eol, eof: pend_eof};
  assign pop       = pix_valid & pix_ready;

  // Beats that will be held after this cycle: stored + returning - leaving.
  // A new read is allowed only if that leaves room for its data.
  assign commit_cnt = {1'b0, occ} + {2'b00, rd_pending} - {2'b00, pop};
  assign rd_en      = (state == ST_RUN) && !abort && (commit_cnt < 3'd2);

  assign mem_rd_en = rd_en;
  assign mem_addr  = addr;

  pix_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (rd_pending),
    .push_beat (push_beat),
    .out_valid (pix_valid),
    .out_ready (pix_ready),
    .out_beat  (out_beat),
    .occupancy (occ)
  );

  assign pix_data = out_beat.data;
  assign pix_sof  = out_beat.sof;
  assign pix_eol  = out_beat.eol;
  assign pix_eof  = out_beat.eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      col        <= '0;
      row        <= '0;
      rd_pending <= 1'b0;
      pend_sof   <= 1'b0;
      pend_eol   <= 1'b0;
      pend_eof   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      rd_pending <= rd_en;
      if (rd_en) begin
        pend_sof <= cur_sof;
        pend_eol <= cur_eol;
        pend_eof <= cur_eof;
      end
      if (abort) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        rd_pending <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_RUN;
              busy  <= 1'b1;
              addr  <= '0;
              col   <= '0;
              row   <= '0;
            end
          end
          ST_RUN: begin
            if (rd_en) begin
              if (addr == LAST_ADDR) begin
                state <= ST_DRAIN;
              end else begin
                addr <= addr + 1'b1;
              end
              if (cur_eol) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            if (pop && pix_eof) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef XRAY_STREAM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sum <= 16'h0000;
      sum_valid <= 1'b0;
    end else if (abort) begin
      sum_valid <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      frame_sum <= 16'h0000;
      sum_valid <= 1'b0;
    end else begin
      if (pop) begin
        frame_sum <= frame_sum + 16'(pix_data);
      end
      if (state == ST_DRAIN && pop && pix_eof) begin
        sum_valid <= 1'b1;
      end
    end
  end
`endif

endmodule
